// File: rtl/operand_entry.sv
// Keypad operand entry: builds decimal operands digit by digit and commits them in sequence.
// All outputs are registered and only change on the cycle after a key press event.
module operand_entry #(
  parameter int WIDTH        = 8,
  parameter int MAX_DIGITS   = 3,
  parameter int NUM_OPERANDS = 2,
  localparam int DW = $clog2(MAX_DIGITS + 1),
  localparam int IW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    key_value,
  input  logic                          key_pressed,
  output logic [WIDTH-1:0]              entry_value,
  output logic [DW-1:0]                 digit_count,
  output logic [IW-1:0]                 active_idx,
  output logic [NUM_OPERANDS*WIDTH-1:0] operands,
  output logic                          operands_valid,
  output logic                          commit_pulse,
  output logic                          err_pulse
);

  // state | meaning
  // ENTRY | digits are being typed into the active operand
  // DONE  | all operands committed; a digit starts a new round
  typedef enum logic {ENTRY, DONE} state_t;

  localparam logic [DW-1:0] MAX_COUNT = DW'(MAX_DIGITS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_OPERANDS - 1);

  state_t                          state_q, state_d;
  logic                            key_prev;
  logic                            key_event;
  logic                            is_digit;
  logic [WIDTH+3:0]                cand;
  logic [WIDTH-1:0]                entry_d;
  logic [DW-1:0]                   count_d;
  logic [IW-1:0]                   idx_d;
  logic [NUM_OPERANDS*WIDTH-1:0]   ops_d;
  logic                            valid_d, commit_d, err_d;

  assign key_event = key_pressed & ~key_prev;
  assign is_digit  = (key_value <= 4'd9);
  // Four spare bits hold any overflow of value*10+d so the range check is a simple top-bits test.
  assign cand = ({4'b0, entry_value} * (WIDTH+4)'(10)) + {{WIDTH{1'b0}}, key_value};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ENTRY;
      key_prev       <= 1'b0;
      entry_value    <= '0;
      digit_count    <= '0;
      active_idx     <= '0;
      operands       <= '0;
      operands_valid <= 1'b0;
      commit_pulse   <= 1'b0;
      err_pulse      <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_prev       <= key_pressed;
      entry_value    <= entry_d;
      digit_count    <= count_d;
      active_idx     <= idx_d;
      operands       <= ops_d;
      operands_valid <= valid_d;
      commit_pulse   <= commit_d;
      err_pulse      <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_value;
    count_d  = digit_count;
    idx_d    = active_idx;
    ops_d    = operands;
    valid_d  = operands_valid;
    commit_d = 1'b0;
    err_d    = 1'b0;

    if (key_event) begin
      if (key_value == 4'hD) begin
        state_d = ENTRY;
        entry_d = '0;
        count_d = '0;
        idx_d   = '0;
        ops_d   = '0;
        valid_d = 1'b0;
      end else if (state_q == ENTRY) begin
        if (is_digit) begin
          if ((digit_count < MAX_COUNT) && (cand[WIDTH+3:WIDTH] == 4'd0)) begin
            entry_d = cand[WIDTH-1:0];
            count_d = digit_count + DW'(1);
          end else begin
            err_d = 1'b1;
          end
        end else begin
          case (key_value)
            4'hA: begin
              entry_d = '0;
              count_d = '0;
            end
            4'hB: begin
              if (digit_count != '0) begin
                entry_d = entry_value / WIDTH'(10);
                count_d = digit_count - DW'(1);
              end
            end
            4'hC: begin
              if (digit_count == '0) begin
                err_d = 1'b1;
              end else begin
                for (int i = 0; i < NUM_OPERANDS; i++) begin
                  if (active_idx == IW'(i)) ops_d[i*WIDTH +: WIDTH] = entry_value;
                end
                commit_d = 1'b1;
                entry_d  = '0;
                count_d  = '0;
                if (active_idx < LAST_IDX) begin
                  idx_d = active_idx + IW'(1);
                end else begin
                  idx_d   = '0;
                  state_d = DONE;
                  valid_d = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end else if (is_digit) begin
        // A digit after a completed round discards the old operands and starts over.
        state_d = ENTRY;
        ops_d   = '0;
        valid_d = 1'b0;
        idx_d   = '0;
        entry_d = WIDTH'(key_value);
        count_d = DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: keypad rule model checked every cycle, plus directed literal checks.
module tb_operand_entry;
  localparam int W  = 8;
  localparam int MD = 3;
  localparam int NO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    key_value;
  logic          key_pressed;
  logic [W-1:0]  entry_value;
  logic [1:0]    digit_count;
  logic [0:0]    active_idx;
  logic [NO*W-1:0] operands;
  logic          operands_valid;
  logic          commit_pulse;
  logic          err_pulse;

  int total = 0;
  int bad   = 0;
  int ncommit;
  logic last_commit, last_err;

  operand_entry #(.WIDTH(W), .MAX_DIGITS(MD), .NUM_OPERANDS(NO)) dut (
    .clk(clk), .rst(rst), .key_value(key_value), .key_pressed(key_pressed),
    .entry_value(entry_value), .digit_count(digit_count), .active_idx(active_idx),
    .operands(operands), .operands_valid(operands_valid),
    .commit_pulse(commit_pulse), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the keypad rules, updated at each rising edge.
  int m_entry, m_dc, m_idx, m_valid, m_commit, m_err;
  int m_ops[NO];
  bit m_prev, m_done, m_started;

  task automatic model_key(input int k);
    if (k == 13) begin
      m_entry = 0; m_dc = 0; m_idx = 0; m_valid = 0; m_done = 0;
      foreach (m_ops[i]) m_ops[i] = 0;
    end else if (!m_done) begin
      if (k <= 9) begin
        if (m_dc < MD && m_entry * 10 + k <= (1 << W) - 1) begin
          m_entry = m_entry * 10 + k; m_dc++;
        end else m_err = 1;
      end else if (k == 10) begin
        m_entry = 0; m_dc = 0;
      end else if (k == 11) begin
        if (m_dc > 0) begin m_entry = m_entry / 10; m_dc--; end
      end else if (k == 12) begin
        if (m_dc == 0) m_err = 1;
        else begin
          m_ops[m_idx] = m_entry; m_commit = 1; m_entry = 0; m_dc = 0;
          if (m_idx < NO - 1) m_idx++;
          else begin m_idx = 0; m_done = 1; m_valid = 1; end
        end
      end
    end else if (k <= 9) begin
      foreach (m_ops[i]) m_ops[i] = 0;
      m_valid = 0; m_idx = 0; m_done = 0; m_entry = k; m_dc = 1;
    end
  endtask

  always @(posedge clk) begin
    m_commit = 0;
    m_err    = 0;
    if (rst) begin
      m_started = 1; m_prev = 0;
      m_entry = 0; m_dc = 0; m_idx = 0; m_valid = 0; m_done = 0;
      foreach (m_ops[i]) m_ops[i] = 0;
    end else begin
      if (key_pressed && !m_prev) model_key(int'(key_value));
      m_prev = key_pressed;
    end
  end

  always @(negedge clk) begin
    logic [NO*W-1:0] exp_ops;
    if (m_started) begin
      for (int i = 0; i < NO; i++) exp_ops[i*W +: W] = W'(m_ops[i]);
      chk("entry_value", 64'(entry_value), 64'(m_entry));
      chk("digit_count", 64'(digit_count), 64'(m_dc));
      chk("active_idx", 64'(active_idx), 64'(m_idx));
      chk("operands", 64'(operands), 64'(exp_ops));
      chk("operands_valid", 64'(operands_valid), 64'(m_valid));
      chk("commit_pulse", 64'(commit_pulse), 64'(m_commit));
      chk("err_pulse", 64'(err_pulse), 64'(m_err));
      chk("pulse_exclusive", 64'(commit_pulse & err_pulse), 64'(0));
    end
  end

  task automatic press(input logic [3:0] k);
    key_value = k;
    key_pressed = 1'b1;
    @(negedge clk);
    last_commit = commit_pulse;
    last_err    = err_pulse;
    if (commit_pulse) ncommit++;
    key_pressed = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; key_pressed = 1'b0; key_value = 4'h0; ncommit = 0;
    repeat (2) @(negedge clk);
    chk("rst_entry", 64'(entry_value), 0);
    chk("rst_ops", 64'(operands), 0);
    chk("rst_valid", 64'(operands_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    // Two operands 12 and 34.
    press(4'h1); press(4'h2); press(4'hC); press(4'h3); press(4'h4); press(4'hC);
    chk("r023_op0", 64'(operands[7:0]), 12);
    chk("r023_op1", 64'(operands[15:8]), 34);
    chk("r023_commits", 64'(ncommit), 2);
    chk("r023_valid", 64'(operands_valid), 1);
    chk("r023_idx", 64'(active_idx), 0);

    // Non-digits in DONE do nothing.
    press(4'hC);
    chk("done_c_commit", 64'(last_commit), 0);
    chk("done_c_err", 64'(last_err), 0);
    press(4'hB); press(4'hA); press(4'hE);
    chk("done_ops_kept", 64'(operands), 64'h220C);

    // New round from DONE, then D mid-entry.
    press(4'h9);
    chk("r027_ops", 64'(operands), 0);
    chk("r027_valid", 64'(operands_valid), 0);
    chk("r027_entry", 64'(entry_value), 9);
    chk("r027_dc", 64'(digit_count), 1);
    press(4'h5);
    chk("r027_entry95", 64'(entry_value), 95);
    press(4'hD);
    chk("r027_clr_entry", 64'(entry_value), 0);
    chk("r027_clr_dc", 64'(digit_count), 0);

    // 255 boundary.
    press(4'h2); press(4'h5); press(4'h5); press(4'hC);
    chk("r024_op0", 64'(operands[7:0]), 255);
    chk("r024_idx", 64'(active_idx), 1);
    press(4'h2); press(4'h5);
    chk("r024_entry25", 64'(entry_value), 25);
    press(4'h6);
    chk("r024_err", 64'(last_err), 1);
    chk("r024_entry", 64'(entry_value), 25);
    chk("r024_dc", 64'(digit_count), 2);
    press(4'hD);

    // Leading zeros and digit limit.
    press(4'h0);
    chk("r025_zero_dc", 64'(digit_count), 1);
    press(4'h0); press(4'h7);
    chk("r025_entry", 64'(entry_value), 7);
    chk("r025_dc", 64'(digit_count), 3);
    press(4'h8);
    chk("r025_err", 64'(last_err), 1);
    press(4'hB);
    chk("r025_bs_entry", 64'(entry_value), 0);
    chk("r025_bs_dc", 64'(digit_count), 2);
    press(4'hB); press(4'hB); press(4'hB);
    chk("bs_empty_err", 64'(last_err), 0);
    chk("bs_empty_dc", 64'(digit_count), 0);
    press(4'hD);

    // Held key gives one event; enter on empty entry errors.
    key_value = 4'h5; key_pressed = 1'b1;
    repeat (10) @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
    chk("r026_entry", 64'(entry_value), 5);
    chk("r026_dc", 64'(digit_count), 1);
    press(4'hA); press(4'hC);
    chk("r026_err", 64'(last_err), 1);
    chk("r026_commit", 64'(last_commit), 0);
    press(4'hD);

    // Reset mid-entry overrides a simultaneous press.
    press(4'h4); press(4'h2);
    chk("r028_entry42", 64'(entry_value), 42);
    key_value = 4'h7; key_pressed = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("r028_entry", 64'(entry_value), 0);
    chk("r028_dc", 64'(digit_count), 0);
    rst = 1'b0; key_pressed = 1'b0;
    @(negedge clk);
    chk("r028_after", 64'(entry_value), 0);

    // Key held through reset release produces one event.
    key_value = 4'h3; key_pressed = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("r022_entry", 64'(entry_value), 3);
    chk("r022_dc", 64'(digit_count), 1);
    key_pressed = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (unsigned).
REQ-002 Parameter MAX_DIGITS, default 3, maximum decimal digits per operand.
REQ-003 Parameter NUM_OPERANDS, default 2, operands entered in sequence (index 0 first).
REQ-004 Ports shall be:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_value  in  4  key code: 0-9 digit, A clear entry, B backspace, C enter, D clear all, E/F ignored.
- key_pressed  in  1  key-held level, already debounced and synchronous to clk.
- entry_value  out  WIDTH  value of the operand being entered.
- digit_count  out  clog2(MAX_DIGITS+1)  digits in entry_value.
- active_idx  out  clog2(NUM_OPERANDS) (min 1)  index of the operand being entered.
- operands  out  NUM_OPERANDS*WIDTH  committed operands; operand i in bits [i*WIDTH +: WIDTH].
- operands_valid  out  1  level: all operands committed.
- commit_pulse  out  1  one-cycle pulse per accepted enter.
- err_pulse  out  1  one-cycle pulse per rejected key.

Function
REQ-005 Key event: cycle where key_pressed=1 and the registered previous key_pressed=0; only events act, and a held key yields exactly one event.
REQ-006 Event effects shall be visible in registered outputs the cycle after the event; outputs shall change at no other time.
REQ-007 The FSM shall have states ENTRY and DONE; reset state ENTRY.
REQ-008 ENTRY, digit d: cand = entry_value*10 + d, computed WIDTH+4 bits wide; if digit_count < MAX_DIGITS and cand <= 2^WIDTH-1, entry_value<=cand and digit_count+1; else no state change and err_pulse.
REQ-009 Leading zeros count as digits (pressing 0 at entry 0 gives digit_count 1).
REQ-010 ENTRY, B: if digit_count>0, entry_value<=entry_value/10 and digit_count-1; if 0, no change, no error.
REQ-011 ENTRY, A: entry_value<=0, digit_count<=0; active_idx and committed operands unchanged.
REQ-012 ENTRY, C with digit_count=0: no change, err_pulse.
REQ-013 ENTRY, C with digit_count>0: operand[active_idx]<=entry_value, commit_pulse, entry cleared; if active_idx<NUM_OPERANDS-1, active_idx+1; else active_idx<=0, state DONE, operands_valid<=1.
REQ-014 DONE, digit d: all operands<=0, operands_valid<=0, active_idx<=0, state ENTRY, entry_value<=d, digit_count<=1.
REQ-015 DONE, A, B or C: ignored, no pulses.
REQ-016 D in any state: all operands, entry_value, digit_count, active_idx<=0, operands_valid<=0, state ENTRY, no pulses.
REQ-017 E/F in any state: ignored, no pulses.
REQ-018 commit_pulse and err_pulse shall never both be high and shall be 0 outside the cycle after an event.
REQ-019 operands shall remain stable between commits/clears; re-entry of an already committed index is not possible without D or a new round (REQ-014).

Reset
REQ-020 With rst=1 at a clock edge, next cycle: state ENTRY, entry_value=0, digit_count=0, active_idx=0, operands=0, operands_valid=0, commit_pulse=0, err_pulse=0, previous key_pressed register=0.
REQ-021 rst shall override any simultaneous key event; partial entry is discarded mid-operation.
REQ-022 If key_pressed is high when rst deasserts, one event shall occur on the first cycle after reset (previous register is 0).

Verification (WIDTH=8, MAX_DIGITS=3, NUM_OPERANDS=2)
REQ-023 Keys 1,2,C,3,4,C -> operands[7:0]=12, operands[15:8]=34, two commit_pulses, operands_valid=1, active_idx=0.
REQ-024 Keys 2,5,5,C then 2,5,6 -> operand0=255; entry 25 after "25", "6" gives err_pulse, entry_value stays 25, digit_count 2.
REQ-025 Keys 0,0,7,8 -> entry_value=7, digit_count=3, "8" gives err_pulse; B -> entry_value=0, digit_count=2.
REQ-026 key_pressed held high 10 cycles with key_value=5 -> entry_value=5 only, single event; C with empty entry -> err_pulse only.
REQ-027 In DONE (operands 12,34), key 9 -> operands=0, operands_valid=0, entry_value=9, digit_count=1; D mid-entry -> all zero.
REQ-028 rst asserted after keys 4,2 -> all outputs zero next cycle; a rising key_pressed in the rst cycle has no effect.
